// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: sequences decoded AHB transfers into APB setup/enable phases.
// Define APB_PREADY_EN to add the Pready port and stretch ST_ENABLE until Pready is high.
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic              Hwrite,
    input  logic [SEL_W-1:0]  tempselx,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Prdata,
`ifdef APB_PREADY_EN
    input  logic              Pready,
`endif
    output logic              Pwrite,
    output logic              Penable,
    output logic [SEL_W-1:0]  Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout,
    output logic [DATA_W-1:0] Hrdata
);
    typedef enum logic [1:0] {ST_IDLE, ST_WWAIT, ST_SETUP, ST_ENABLE} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d, pselx_q, pselx_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d, penable_q, penable_d;
    logic                ready, accept;

`ifdef APB_PREADY_EN
    assign ready = Pready;
`else
    assign ready = 1'b1;
`endif

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            pselx_q   <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            pselx_q   <= pselx_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            penable_q <= penable_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE:   accept = valid;
            ST_WWAIT: begin
                pwdata_d = Hwdata;
                state_d  = ST_SETUP;
            end
            ST_SETUP:  state_d = ST_ENABLE;
            ST_ENABLE: begin
                accept  = ready & valid;
                state_d = ready ? ST_IDLE : ST_ENABLE;
            end
            default:   state_d = ST_IDLE;
        endcase
        if (accept) begin
            paddr_d  = Haddr;
            sel_d    = tempselx;
            pwrite_d = Hwrite;
            state_d  = Hwrite ? ST_WWAIT : ST_SETUP;
        end
        // APB outputs are registered, so they are decoded from the next state.
        penable_d = state_d == ST_ENABLE;
        pselx_d   = (state_d == ST_SETUP || state_d == ST_ENABLE) ? sel_d : '0;
    end

    assign Pwrite    = pwrite_q;
    assign Penable   = penable_q;
    assign Pselx     = pselx_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;
    assign Hreadyout = state_q == ST_IDLE || (state_q == ST_ENABLE && ready);
    assign Hrdata    = Prdata;
endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: transaction-level model predicts per-cycle APB/AHB outputs.
module tb_apb_fsm_controller;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 3;

    logic          Hclk = 1'b0, Hresetn = 1'b1, valid = 1'b0, Hwrite = 1'b0;
    logic [AW-1:0] Haddr = '0;
    logic [SW-1:0] tempselx = '0;
    logic [DW-1:0] Hwdata = '0, Prdata = '0;
`ifdef APB_PREADY_EN
    logic          Pready = 1'b1;
    logic          pr = 1'b1;
`endif
    logic          Pwrite, Penable, Hreadyout;
    logic [SW-1:0] Pselx;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata, Hrdata;

    int total = 0, passed = 0;
    logic [AW-1:0] m_paddr = '0;
    logic [DW-1:0] m_pwdata = '0;
    logic          m_pwrite = 1'b0;
    // expected outputs of the next cycle able to accept a transfer (idle or final enable)
    logic [SW-1:0] s_sel = '0;
    logic          s_en = 1'b0, s_rdy = 1'b1;

    apb_fsm_controller #(.ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Haddr(Haddr), .Hwrite(Hwrite),
        .tempselx(tempselx), .Hwdata(Hwdata), .Prdata(Prdata),
`ifdef APB_PREADY_EN
        .Pready(Pready),
`endif
        .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx), .Paddr(Paddr),
        .Pwdata(Pwdata), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input logic [SW-1:0] es, input logic ee, input logic er, input logic v,
                        input logic w, input logic [AW-1:0] a, input logic [SW-1:0] ts,
                        input logic [DW-1:0] wd);
        @(negedge Hclk);
        chk("Pselx", 64'(Pselx), 64'(es));
        chk("Penable", 64'(Penable), 64'(ee));
        chk("Paddr", 64'(Paddr), 64'(m_paddr));
        chk("Pwdata", 64'(Pwdata), 64'(m_pwdata));
        chk("Pwrite", 64'(Pwrite), 64'(m_pwrite));
        valid = v; Hwrite = w; Haddr = a; tempselx = ts; Hwdata = wd;
        Prdata = $urandom;
`ifdef APB_PREADY_EN
        Pready = pr;
`endif
        #1;
        chk("Hreadyout", 64'(Hreadyout), 64'(er));
        chk("Hrdata", 64'(Hrdata), 64'(Prdata));
    endtask

    task automatic noise(input logic [SW-1:0] es, input logic ee, input logic er, input logic [DW-1:0] wd);
        tick(es, ee, er, 1'($urandom), 1'($urandom), $urandom, 3'($urandom), wd);
    endtask

    task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [SW-1:0] s,
                        input logic [DW-1:0] wd, input int gap, input int stall);
        for (int i = 0; i < gap; i++) begin
            tick(s_sel, s_en, s_rdy, 1'b0, 1'($urandom), $urandom, 3'($urandom), $urandom);
            s_sel = '0; s_en = 1'b0; s_rdy = 1'b1;
        end
        tick(s_sel, s_en, s_rdy, 1'b1, w, a, s, $urandom);
        m_paddr = a; m_pwrite = w;
        if (w) begin
            noise('0, 1'b0, 1'b0, wd);
            m_pwdata = wd;
        end
        noise(s, 1'b0, 1'b0, $urandom);
`ifdef APB_PREADY_EN
        for (int i = 0; i < stall; i++) begin
            pr = 1'b0;
            noise(s, 1'b1, 1'b0, $urandom);
        end
        pr = 1'b1;
`else
        if (stall < 0) $display("negative stall ignored");
`endif
        s_sel = s; s_en = 1'b1; s_rdy = 1'b1;
    endtask

    initial begin
        #2 Hresetn = 1'b0;
        #1;
        chk("rst_Pselx", 64'(Pselx), 0);
        chk("rst_Penable", 64'(Penable), 0);
        chk("rst_Hreadyout", 64'(Hreadyout), 1);
        chk("rst_Paddr", 64'(Paddr), 0);
        repeat (2) @(posedge Hclk);
        @(negedge Hclk) Hresetn = 1'b1;
        xfer(1'b0, 32'h8000_0010, 3'b001, '0, 1, 3);
        xfer(1'b1, 32'h8400_0004, 3'b010, 32'hDEAD_BEEF, 2, 0);
        xfer(1'b0, 32'h8000_0020, 3'b100, '0, 0, 0);
        xfer(1'b1, 32'h8000_0024, 3'b001, 32'h1234_5678, 0, 1);
        xfer(1'b0, 32'h8000_0030, 3'b010, '0, 5, 0);
        for (int n = 0; n < 40; n++)
            xfer(1'($urandom), $urandom, 3'(1 << $urandom_range(0, 2)), $urandom,
                 $urandom_range(0, 2), $urandom_range(0, 3));
        xfer(1'b1, 32'h8000_0040, 3'b100, 32'hCAFE_F00D, 0, 0);
        @(negedge Hclk);
        chk("pre_rst_Penable", 64'(Penable), 1);
        Hresetn = 1'b0; valid = 1'b1; Hwrite = 1'b1;
        #1;
        chk("mid_rst_Pselx", 64'(Pselx), 0);
        chk("mid_rst_Penable", 64'(Penable), 0);
        chk("mid_rst_Paddr", 64'(Paddr), 0);
        chk("mid_rst_Pwdata", 64'(Pwdata), 0);
        chk("mid_rst_Pwrite", 64'(Pwrite), 0);
        chk("mid_rst_Hreadyout", 64'(Hreadyout), 1);
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        Hresetn = 1'b1; valid = 1'b0;
        m_paddr = '0; m_pwdata = '0; m_pwrite = 1'b0;
        s_sel = '0; s_en = 1'b0; s_rdy = 1'b1;
        xfer(1'b0, 32'h8000_0050, 3'b001, '0, 2, 0);
        tick(s_sel, s_en, s_rdy, 1'b0, 1'b0, '0, '0, '0);
        tick('0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
